y86_writeback_pc_unit: RTL and testbench

// - Consumer end of the Y86-64 execute interface: accepts one executed instruction (icode/ifun/cnd/valE/valM/valC/valP/dstE/dstM) per handshake.
// - Sequences register-file writes and commits the next PC, retiring one instruction at a time.
// - Tracks processor status (AOK/HLT/ADR/INS); stops accepting work after halt or fault.

---
 rtl/y86_writeback_pc_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_y86_writeback_pc_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_writeback_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : y86_writeback_pc_unit
// Description : Y86-64 write-back and PC-commit stage. Accepts one executed
//               instruction per handshake, sequences register-file writes,
//               commits the next PC and tracks processor status.
//               Optional feature macro: WB_DUAL_PORT_EN (second write port,
//               valM written alongside valE, WRITE_M state skipped).
// Revision    : 1.0 - initial release
// ============================================================================
module y86_writeback_pc_unit #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter logic [3:0]       REG_NONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic [WIDTH-1:0] valC,
  input  logic [WIDTH-1:0] valP,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic             mem_err,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] pc,
  output logic [2:0]       stat,
  output logic             retired
`ifdef WB_DUAL_PORT_EN
  ,
  output logic             wr2_en,
  output logic [3:0]       wr2_addr,
  output logic [WIDTH-1:0] wr2_data
`endif
);

  localparam logic [2:0] c_STAT_AOK = 3'd1;
  localparam logic [2:0] c_STAT_HLT = 3'd2;
  localparam logic [2:0] c_STAT_ADR = 3'd3;
  localparam logic [2:0] c_STAT_INS = 3'd4;

  localparam logic [3:0] c_I_HALT = 4'h0;
  localparam logic [3:0] c_I_CMOV = 4'h2;
  localparam logic [3:0] c_I_JXX  = 4'h7;
  localparam logic [3:0] c_I_CALL = 4'h8;
  localparam logic [3:0] c_I_RET  = 4'h9;
  localparam logic [3:0] c_I_MAX  = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE_E = 3'd1,
    S_WRITE_M = 3'd2,
    S_COMMIT  = 3'd3,
    S_HALT    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [3:0]       r_icode;
  logic             r_cnd;
  logic [WIDTH-1:0] r_val_m;
  logic [WIDTH-1:0] r_val_c;
  logic [WIDTH-1:0] r_val_p;
  logic             r_wr_en;
  logic [3:0]       r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic [WIDTH-1:0] r_pc;
  logic [2:0]       r_stat;
  logic             r_retired;

  logic             w_accept;
  logic             w_is_halt;
  logic             w_is_ins;
  logic             w_we_e;
  logic             w_use_m;
  logic [WIDTH-1:0] w_new_pc;
  logic             w_unused;

  // ifun only selects the condition inside execute; cnd already carries it.
  assign w_unused  = ^ifun;

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_halt = (icode == c_I_HALT);
  assign w_is_ins  = (icode > c_I_MAX);
  // Conditional move only writes when the condition held.
  assign w_we_e    = (dstE != REG_NONE) && ((icode != c_I_CMOV) || cnd);
  assign w_use_m   = (dstM != REG_NONE);

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign pc        = r_pc;
  assign stat      = r_stat;
  assign retired   = r_retired;

  // Next-PC selection from the latched instruction.
  always_comb begin
    w_new_pc = r_val_p;
    if (r_icode == c_I_CALL) begin
      w_new_pc = r_val_c;
    end else if ((r_icode == c_I_JXX) && r_cnd) begin
      w_new_pc = r_val_c;
    end else if (r_icode == c_I_RET) begin
      w_new_pc = r_val_m;
    end
  end

`ifndef WB_DUAL_PORT_EN
  logic [3:0] r_dst_m;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; halt and faults are classified on the accept edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_halt) begin
            w_state_next = S_HALT;
          end else if (w_is_ins || mem_err) begin
            w_state_next = S_FAULT;
          end else begin
            w_state_next = S_WRITE_E;
          end
        end
      end
`ifdef WB_DUAL_PORT_EN
      S_WRITE_E: w_state_next = S_COMMIT;
`else
      S_WRITE_E: w_state_next = (r_dst_m != REG_NONE) ? S_WRITE_M : S_COMMIT;
`endif
      S_WRITE_M: w_state_next = S_COMMIT;
      S_COMMIT:  w_state_next = S_IDLE;
      S_HALT:    w_state_next = S_HALT;
      S_FAULT:   w_state_next = S_FAULT;
      default:   w_state_next = S_IDLE;
    endcase
  end

`ifdef WB_DUAL_PORT_EN
  logic             r_wr2_en;
  logic [3:0]       r_wr2_addr;
  logic [WIDTH-1:0] r_wr2_data;

  assign wr2_en   = r_wr2_en;
  assign wr2_addr = r_wr2_addr;
  assign wr2_data = r_wr2_data;

  // Second write port: valM goes out in the same cycle as valE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr2_en   <= 1'b0;
      r_wr2_addr <= 4'h0;
      r_wr2_data <= {WIDTH{1'b0}};
    end else begin
      r_wr2_en <= 1'b0;
      if (w_accept && !w_is_halt && !w_is_ins && !mem_err) begin
        r_wr2_en   <= w_use_m;
        r_wr2_addr <= dstM;
        r_wr2_data <= valM;
      end
    end
  end
`endif

  // Instruction latch, register-file write strobes, status and PC commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode   <= 4'h0;
      r_cnd     <= 1'b0;
      r_val_m   <= {WIDTH{1'b0}};
      r_val_c   <= {WIDTH{1'b0}};
      r_val_p   <= {WIDTH{1'b0}};
`ifndef WB_DUAL_PORT_EN
      r_dst_m   <= 4'h0;
`endif
      r_wr_en   <= 1'b0;
      r_wr_addr <= 4'h0;
      r_wr_data <= {WIDTH{1'b0}};
      r_pc      <= RESET_PC;
      r_stat    <= c_STAT_AOK;
      r_retired <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_retired <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_icode <= icode;
            r_cnd   <= cnd;
            r_val_m <= valM;
            r_val_c <= valC;
            r_val_p <= valP;
`ifndef WB_DUAL_PORT_EN
            r_dst_m <= dstM;
`endif
            if (w_is_halt) begin
              r_stat <= c_STAT_HLT;
            end else if (w_is_ins) begin
              r_stat <= c_STAT_INS;
            end else if (mem_err) begin
              r_stat <= c_STAT_ADR;
            end else begin
`ifdef WB_DUAL_PORT_EN
              // Same destination on both ports: valM wins, port 1 stays quiet.
              r_wr_en <= w_we_e && !(w_use_m && (dstE == dstM));
`else
              r_wr_en <= w_we_e;
`endif
              r_wr_addr <= dstE;
              r_wr_data <= valE;
            end
          end
        end
        S_WRITE_E: begin
`ifdef WB_DUAL_PORT_EN
          r_retired <= 1'b1;
`else
          if (r_dst_m != REG_NONE) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_dst_m;
            r_wr_data <= r_val_m;
          end else begin
            r_retired <= 1'b1;
          end
`endif
        end
        S_WRITE_M: r_retired <= 1'b1;
        S_COMMIT:  r_pc      <= w_new_pc;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_writeback_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_writeback_pc_unit
// Description : Self-checking scoreboard bench for y86_writeback_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_writeback_pc_unit;

  localparam int WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic             cnd;
  logic [WIDTH-1:0] valE, valM, valC, valP;
  logic [3:0]       dstE, dstM;
  logic             mem_err;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] pc;
  logic [2:0]       stat;
  logic             retired;

  y86_writeback_pc_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .icode    (icode),
    .ifun     (ifun),
    .cnd      (cnd),
    .valE     (valE),
    .valM     (valM),
    .valC     (valC),
    .valP     (valP),
    .dstE     (dstE),
    .dstM     (dstM),
    .mem_err  (mem_err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pc       (pc),
    .stat     (stat),
    .retired  (retired)
  );

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
    int          due;
  } wr_t;

  typedef struct {
    logic [63:0] v;
    int          due;
  } pc_t;

  wr_t         wq[$];
  pc_t         pq[$];
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [63:0] exp_pc;
  logic [2:0]  exp_stat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: pops expected writes and PC commits as they become due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wq.size() > 0 && cyc == wq[0].due) begin
        chk("wr_en", {63'd0, wr_en}, 64'd1);
        chk("wr_addr", {60'd0, wr_addr}, {60'd0, wq[0].a});
        chk("wr_data", wr_data, wq[0].d);
        void'(wq.pop_front());
      end else if (wr_en) begin
        chk("wr_unexpected", {63'd0, wr_en}, 64'd0);
      end
      if (retired || (pq.size() > 0 && cyc == pq[0].due - 1))
        chk("retired", {63'd0, retired}, {63'd0, (pq.size() > 0 && cyc == pq[0].due - 1)});
      if (pq.size() > 0 && cyc == pq[0].due) begin
        chk("pc_commit", pc, pq[0].v);
        void'(pq.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 64'h0);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    wq.delete();
    pq.delete();
    exp_pc   = 64'h0;
    exp_stat = 3'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);
  endtask

  // Drive one instruction, wait for acceptance, and record the model's expectations.
  task automatic send(input logic [3:0] ic, input logic c, input logic [63:0] ve,
                      input logic [63:0] vm, input logic [63:0] vc, input logic [63:0] vp,
                      input logic [3:0] de, input logic [3:0] dm, input logic me);
    int guard;
    int n;
    logic use_m;
    logic [63:0] npc;
    wr_t w;
    pc_t p;
    guard = 0;
    @(negedge clk);
    icode = ic; ifun = 4'h0; cnd = c; valE = ve; valM = vm; valC = vc; valP = vp;
    dstE = de; dstM = dm; mem_err = me; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    n = cyc;
    in_valid = 1'b0;
    if (ic == 4'h0) begin
      exp_stat = 3'd2;
    end else if (ic > 4'hB) begin
      exp_stat = 3'd4;
    end else if (me) begin
      exp_stat = 3'd3;
    end else begin
      if (de != 4'hF && (ic != 4'h2 || c)) begin
        w.a = de; w.d = ve; w.due = n;
        wq.push_back(w);
      end
      use_m = (dm != 4'hF);
      if (use_m) begin
        w.a = dm; w.d = vm; w.due = n + 1;
        wq.push_back(w);
      end
      if (ic == 4'h8)             npc = vc;
      else if (ic == 4'h7 && c)   npc = vc;
      else if (ic == 4'h9)        npc = vm;
      else                        npc = vp;
      exp_pc = npc;
      p.v = npc;
      p.due = n + 2 + (use_m ? 1 : 0);
      pq.push_back(p);
    end
  endtask

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    in_valid = 1'b0; icode = 4'h1; ifun = 4'h0; cnd = 1'b0;
    valE = '0; valM = '0; valC = '0; valP = '0;
    dstE = 4'hF; dstM = 4'hF; mem_err = 1'b0;
    rst_n = 1'b1;
    #3;
    do_reset();
    chk("rst_retired", {63'd0, retired}, 64'd0);
    chk("rst_wr_addr", {60'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);

    // irmovq, popq (distinct and same destinations), jumps, cmov, ret, call
    send(4'h3, 1'b0, 64'h2A, 64'h0, 64'h0, 64'h0A, 4'h0, 4'hF, 1'b0);
    send(4'hB, 1'b0, 64'h108, 64'h55, 64'h0, 64'h0C, 4'h4, 4'h3, 1'b0);
    send(4'hB, 1'b0, 64'h200, 64'h77, 64'h0, 64'h0E, 4'h4, 4'h4, 1'b0);
    send(4'h7, 1'b0, 64'h0, 64'h0, 64'h40, 64'h20, 4'hF, 4'hF, 1'b0);
    send(4'h7, 1'b1, 64'h0, 64'h0, 64'h40, 64'h20, 4'hF, 4'hF, 1'b0);
    send(4'h2, 1'b0, 64'h5, 64'h0, 64'h0, 64'h42, 4'h1, 4'hF, 1'b0);
    send(4'h2, 1'b1, 64'h6, 64'h0, 64'h0, 64'h44, 4'h1, 4'hF, 1'b0);
    send(4'h9, 1'b0, 64'h110, 64'h99, 64'h0, 64'h46, 4'h4, 4'hF, 1'b0);
    send(4'h8, 1'b0, 64'hF8, 64'h0, 64'h300, 64'hA9, 4'h4, 4'hF, 1'b0);
    send(4'h3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF6, 4'hE, 4'hF, 1'b0);
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end
    settle();
    chk("pc_after_seq", pc, exp_pc);
    chk("stat_aok", {61'd0, stat}, {61'd0, exp_stat});

    // Reset during WRITE_M of popq abandons the instruction
    send(4'hB, 1'b0, 64'h1000, 64'h2000, 64'h0, 64'h3000, 4'h4, 4'h3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("no_partial_commit", pc, 64'h0);
    send(4'h3, 1'b0, 64'h2A, 64'h0, 64'h0, 64'h0A, 4'h0, 4'hF, 1'b0);
    settle();
    chk("pc_after_rst_op", pc, 64'h0A);

    // halt: terminal, later requests ignored
    send(4'h0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h50, 4'h0, 4'h0, 1'b0);
    chk("halt_stat", {61'd0, stat}, 64'd2);
    chk("halt_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    icode = 4'h3; dstE = 4'h1; dstM = 4'hF; valE = 64'h77; valP = 64'h80; in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("halt_pc_hold", pc, 64'h0A);
    chk("halt_stat_hold", {61'd0, stat}, 64'd2);
    chk("halt_ready_hold", {63'd0, in_ready}, 64'd0);

    // invalid instruction fault
    do_reset();
    send(4'hC, 1'b0, 64'h1, 64'h0, 64'h0, 64'h60, 4'h2, 4'hF, 1'b0);
    chk("ins_stat", {61'd0, stat}, 64'd4);
    settle();
    chk("ins_pc_hold", pc, 64'h0);
    chk("ins_ready", {63'd0, in_ready}, 64'd0);

    // memory fault
    do_reset();
    send(4'h5, 1'b0, 64'h1, 64'h2, 64'h0, 64'h70, 4'hF, 4'h2, 1'b1);
    chk("adr_stat", {61'd0, stat}, 64'd3);
    settle();
    chk("adr_pc_hold", pc, 64'h0);

    chk("sb_drain", 64'(wq.size() + pq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
